// File: rtl/demux2x1_stream_pkg.sv
// Shared types and channel encoding for the packet-aware 1:2 stream demultiplexer.
// The select polarity is deliberately inverted: sel=1 steers to channel 0.
package demux2x1_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  function automatic logic sel_to_ch(input logic sel);
    return sel ? CH0 : CH1;
  endfunction

  function automatic state_t lock_state(input logic ch);
    return (ch == CH0) ? LOCK0 : LOCK1;
  endfunction

endpackage

// File: rtl/demux2x1_stream_slot.sv
// One-entry output register slice (stream_slot): loads a beat, holds it until
// the downstream takes it. Payload keeps its last value while empty.
module demux2x1_stream_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic             free,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;
  logic             last_reg;

  // Free when empty, or when the held beat leaves this same cycle.
  assign free  = !valid_reg || ready;
  assign valid = valid_reg;
  assign data  = data_reg;
  assign last  = last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      last_reg  <= load_last;
    end else if (ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/demux2x1_stream.sv
// Packet-aware 1:2 stream demultiplexer: the first beat's select picks a channel
// and the rest of the packet follows it. Per-channel packet counters for debug.
module demux2x1_stream
  import demux2x1_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  state_t           state_reg;
  state_t           state_next;
  logic             target;
  logic             accept;
  logic [1:0]       slot_ready;
  logic [1:0]       slot_free;
  logic [1:0]       slot_load;
  logic [1:0]       slot_valid;
  logic [1:0]       slot_last;
  logic [WIDTH-1:0] slot_data   [2];
  logic [CNT_W-1:0] pkt_cnt_reg [2];

  assign slot_ready = {out1_ready, out0_ready};

  // in_sel only matters at a packet boundary; a locked packet ignores it.
  always_comb begin
    target = sel_to_ch(in_sel);
    unique case (state_reg)
      LOCK0:   target = CH0;
      LOCK1:   target = CH1;
      default: target = sel_to_ch(in_sel);
    endcase
  end

  assign in_ready = slot_free[target];
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      unique case (state_reg)
        IDLE:    if (!in_last) state_next = lock_state(target);
        default: if (in_last) state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign busy = (state_reg != IDLE);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      assign slot_load[gi] = accept && (target == 1'(gi));

      demux2x1_stream_slot #(
        .WIDTH(WIDTH)
      ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (slot_load[gi]),
        .load_data(in_data),
        .load_last(in_last),
        .ready    (slot_ready[gi]),
        .free     (slot_free[gi]),
        .valid    (slot_valid[gi]),
        .data     (slot_data[gi]),
        .last     (slot_last[gi])
      );

      // Free-running wrap on overflow keeps the counter a plain modulo count.
      always_ff @(posedge clk) begin
        if (rst) begin
          pkt_cnt_reg[gi] <= '0;
        end else if (slot_load[gi] && in_last) begin
          pkt_cnt_reg[gi] <= pkt_cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign out0_data  = slot_data[0];
  assign out0_last  = slot_last[0];
  assign out0_valid = slot_valid[0];
  assign out1_data  = slot_data[1];
  assign out1_last  = slot_last[1];
  assign out1_valid = slot_valid[1];
  assign pkt_cnt0   = pkt_cnt_reg[0];
  assign pkt_cnt1   = pkt_cnt_reg[1];

endmodule

// File: tb/tb_demux2x1_stream.sv
// Directed bench for demux2x1_stream with hand-computed expectations.
// CNT_W is shrunk to 4 so counter wrap is reachable quickly.
module tb_demux2x1_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_last;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_last;
  logic             out1_valid;
  logic             out1_ready;
  logic             busy;
  logic [CNT_W-1:0] pkt_cnt0;
  logic [CNT_W-1:0] pkt_cnt1;

  int checks = 0;
  int errors = 0;

  demux2x1_stream #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out0_last (out0_last),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data (out1_data),
    .out1_last (out1_last),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .busy      (busy),
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and wait (bounded) until it is accepted; leaves in_valid low.
  task automatic send(input logic sel, input logic [WIDTH-1:0] data, input logic last);
    bit accepted;
    accepted = 1'b0;
    in_sel   = sel;
    in_data  = data;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      #1;
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accepted", 32'(accepted), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    in_data    = '0;
    in_sel     = 1'b0;
    in_last    = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    tick();
    tick();
    check("rst_out0_valid", 32'(out0_valid), 32'd0);
    check("rst_out1_valid", 32'(out1_valid), 32'd0);
    check("rst_out0_data", 32'(out0_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt0", 32'(pkt_cnt0), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Single-beat packets, one per channel.
    send(1'b1, 8'hA5, 1'b1);
    check("sb_out0_valid", 32'(out0_valid), 32'd1);
    check("sb_out0_data", 32'(out0_data), 32'hA5);
    check("sb_out0_last", 32'(out0_last), 32'd1);
    check("sb_out1_idle", 32'(out1_valid), 32'd0);
    send(1'b0, 8'h3C, 1'b1);
    check("sb_out1_valid", 32'(out1_valid), 32'd1);
    check("sb_out1_data", 32'(out1_data), 32'h3C);
    check("sb_out0_drained", 32'(out0_valid), 32'd0);
    check("sb_cnt0", 32'(pkt_cnt0), 32'd1);
    check("sb_cnt1", 32'(pkt_cnt1), 32'd1);
    tick();

    // 4-beat packet locked to channel 0 while in_sel toggles.
    for (int k = 0; k < 4; k++) begin
      send((k % 2 == 0) ? 1'b1 : 1'b0, 8'(8'h10 + k), (k == 3));
      check($sformatf("mb_out0_data%0d", k), 32'(out0_data), 32'(8'h10 + k));
      check($sformatf("mb_out1_idle%0d", k), 32'(out1_valid), 32'd0);
      check($sformatf("mb_busy%0d", k), 32'(busy), (k < 3) ? 32'd1 : 32'd0);
    end
    check("mb_cnt0", 32'(pkt_cnt0), 32'd2);
    check("mb_cnt1", 32'(pkt_cnt1), 32'd1);
    tick();

    // Backpressure on out0 must not block a channel-1 packet.
    out0_ready = 1'b0;
    send(1'b1, 8'h55, 1'b1);
    in_sel   = 1'b1;
    in_data  = 8'h66;
    in_last  = 1'b1;
    in_valid = 1'b1;
    #1;
    check("bp_in_ready_ch0", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_out0_hold", 32'(out0_data), 32'h55);
    send(1'b0, 8'h77, 1'b1);
    check("bp_out1_data", 32'(out1_data), 32'h77);
    check("bp_out1_valid", 32'(out1_valid), 32'd1);
    check("bp_out0_valid", 32'(out0_valid), 32'd1);
    out0_ready = 1'b1;
    tick();
    check("bp_out0_drained", 32'(out0_valid), 32'd0);
    check("bp_cnt0", 32'(pkt_cnt0), 32'd3);
    check("bp_cnt1", 32'(pkt_cnt1), 32'd2);

    // Continuous 8-beat stream: drain and load in the same cycle, no bubbles.
    for (int k = 0; k < 8; k++) begin
      in_sel   = 1'b1;
      in_data  = 8'(8'h20 + k);
      in_last  = (k == 7);
      in_valid = 1'b1;
      #1;
      check($sformatf("st_in_ready%0d", k), 32'(in_ready), 32'd1);
      tick();
      check($sformatf("st_out0_data%0d", k), 32'(out0_data), 32'(8'h20 + k));
      check($sformatf("st_out0_valid%0d", k), 32'(out0_valid), 32'd1);
    end
    in_valid = 1'b0;
    check("st_cnt0", 32'(pkt_cnt0), 32'd4);
    tick();

    // Reset in the middle of a packet.
    send(1'b1, 8'h40, 1'b0);
    send(1'b1, 8'h41, 1'b0);
    check("mr_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_out0_valid", 32'(out0_valid), 32'd0);
    check("mr_out1_valid", 32'(out1_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_cnt0", 32'(pkt_cnt0), 32'd0);
    check("mr_cnt1", 32'(pkt_cnt1), 32'd0);
    send(1'b0, 8'h90, 1'b1);
    check("mr_out1_data", 32'(out1_data), 32'h90);
    check("mr_out1_valid", 32'(out1_valid), 32'd1);
    check("mr_out0_valid2", 32'(out0_valid), 32'd0);
    check("mr_cnt1_after", 32'(pkt_cnt1), 32'd1);
    tick();

    // Counter wrap: 16 single-beat packets on channel 0 with a 4-bit counter.
    for (int k = 0; k < 15; k++) send(1'b1, 8'(k), 1'b1);
    check("wr_cnt0_max", 32'(pkt_cnt0), 32'hF);
    send(1'b1, 8'hFF, 1'b1);
    check("wr_cnt0_wrap", 32'(pkt_cnt0), 32'd0);
    check("wr_cnt1_hold", 32'(pkt_cnt1), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
